// File: rtl/path_pkg.sv
// ---------------------------------------------------------------------------
// path_pkg
// Shared definitions for the path pipeline. path_reader, the path writer and
// the Dijkstra engine all import this package, so the coordinate layout and
// the end-of-path marker have a single definition.
//
// Contents
//   coord_t             packed coordinate, x in [31:16], y in [15:0]
//   PATH_SENTINEL       coordinate value that terminates a path
//   PATH_MAX_LEN        default path buffer depth in coordinates
//   rx_state_t          receive FSM states
//   outcome_t           what a captured coordinate does to the transfer
//   coord_is_sentinel() helper to recognise the terminator
// ---------------------------------------------------------------------------
package path_pkg;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } coord_t;

  localparam logic [31:0] PATH_SENTINEL = 32'hFFFF_FFFF;
  localparam int          PATH_MAX_LEN  = 100;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_VALID = 3'd1,
    ACK        = 3'd2,
    DONE       = 3'd3,
    ERR        = 3'd4
  } rx_state_t;

  // Decided at capture time and acted on once the handshake closes.
  typedef enum logic [1:0] {
    OUT_NEXT = 2'd0,  // stored (or harmless), wait for the next coordinate
    OUT_DONE = 2'd1,  // sentinel seen, path complete
    OUT_ERR  = 2'd2   // coordinate rejected, transfer aborted
  } outcome_t;

  function automatic logic coord_is_sentinel(input coord_t c);
    return (c == coord_t'(PATH_SENTINEL));
  endfunction

endpackage

// File: rtl/path_handshake_rx.sv
// ---------------------------------------------------------------------------
// path_handshake_rx
// Four-phase receive FSM for the path transfer. It owns the transfer state
// (IDLE, WAIT_VALID, ACK, DONE, ERR), raises received_coord while in ACK and
// emits a one-cycle capture strobe for each coordinate. The buffer and the
// length counter live in the parent; the parent only tells this FSM, at
// capture time, where the transfer should go once the handshake closes.
//
// Ports
//   clk              in   clock, rising edge
//   reset            in   asynchronous active-low reset
//   start            in   arms a transfer from IDLE/DONE/ERR
//   gave_coord       in   producer strobe
//   capture_outcome  in   classification of the coordinate on the bus now
//   arm              out  one-cycle strobe: a start was accepted
//   capture          out  one-cycle strobe: take the coordinate this cycle
//   received_coord   out  acknowledge to producer
//   finished         out  transfer completed normally
//   error            out  transfer aborted
// ---------------------------------------------------------------------------
module path_handshake_rx
  import path_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     start,
  input  logic     gave_coord,
  input  outcome_t capture_outcome,
  output logic     arm,
  output logic     capture,
  output logic     received_coord,
  output logic     finished,
  output logic     error
);

  rx_state_t state_reg, state_next;
  outcome_t  outcome_reg, outcome_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      outcome_reg <= OUT_NEXT;
    end else begin
      state_reg   <= state_next;
      outcome_reg <= outcome_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    outcome_next = outcome_reg;
    arm          = 1'b0;
    capture      = 1'b0;

    unique case (state_reg)
      IDLE, DONE, ERR: begin
        if (start) begin
          arm        = 1'b1;
          state_next = WAIT_VALID;
        end
      end

      WAIT_VALID: begin
        // Capture happens only on entry to ACK, so a producer that keeps
        // gave_coord high while in ACK cannot be mistaken for a new coord.
        if (gave_coord) begin
          capture      = 1'b1;
          outcome_next = capture_outcome;
          state_next   = ACK;
        end
      end

      ACK: begin
        if (!gave_coord) begin
          unique case (outcome_reg)
            OUT_DONE: state_next = DONE;
            OUT_ERR:  state_next = ERR;
            default:  state_next = WAIT_VALID;
          endcase
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Pure state decodes: reset drops the acknowledge immediately, and DONE
  // and ERR being distinct states keeps finished/error mutually exclusive.
  assign received_coord = (state_reg == ACK);
  assign finished       = (state_reg == DONE);
  assign error          = (state_reg == ERR);

endmodule

// File: rtl/path_reader.sv
// ---------------------------------------------------------------------------
// path_reader
// Receives a path of coordinates from a producer over a four-phase
// handshake and stores it in a register buffer. The path ends with the
// sentinel 32'hFFFF_FFFF, which is acknowledged but not stored. A coordinate
// arriving with the buffer full aborts the transfer with error.
//
// Optional feature: define PATH_READER_BOUNDS_EN to reject coordinates with
// x >= MAP_W or y >= MAP_H (acknowledged, not stored, transfer aborted).
// Without it any non-sentinel coordinate is stored.
//
// Parameters
//   MAX_LEN   buffer depth in coordinates
//   MAP_W     exclusive x bound (bounds check only)
//   MAP_H     exclusive y bound (bounds check only)
//
// Ports
//   clk             in   clock, rising edge
//   reset           in   asynchronous active-low reset
//   start           in   one-cycle pulse arming a new transfer
//   gave_coord      in   producer strobe, coord valid while high
//   coord           in   packed coordinate, x = [31:16], y = [15:0]
//   received_coord  out  acknowledge to producer
//   path            out  captured path, entry 0 first
//   length          out  number of valid entries in path
//   finished        out  transfer complete, held until start or reset
//   error           out  transfer aborted, held until start or reset
// ---------------------------------------------------------------------------
module path_reader
  import path_pkg::*;
#(
  parameter int          MAX_LEN = PATH_MAX_LEN,
  parameter logic [15:0] MAP_W   = 16'd640,
  parameter logic [15:0] MAP_H   = 16'd480
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  logic   gave_coord,
  input  coord_t coord,
  output logic   received_coord,
  output coord_t path [MAX_LEN],
  output integer length,
  output logic   finished,
  output logic   error
);

  // Wide enough to hold MAX_LEN itself, since a full buffer is a legal state.
  localparam int LEN_W = $clog2(MAX_LEN + 1);

`ifdef PATH_READER_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic [LEN_W-1:0] len_reg, len_next;
  logic             arm;
  logic             capture;
  logic             store;
  logic             is_sentinel;
  logic             is_full;
  logic             out_of_range;
  outcome_t         capture_outcome;

  // -------------------------------------------------------------------------
  // Classification of the coordinate currently on the bus. Only meaningful
  // in the cycle the handshake FSM captures it.
  // -------------------------------------------------------------------------
  assign is_sentinel  = coord_is_sentinel(coord);
  assign is_full      = (len_reg == LEN_W'(MAX_LEN));
  assign out_of_range = BOUNDS_EN && ((coord.x >= MAP_W) || (coord.y >= MAP_H));

  always_comb begin
    capture_outcome = OUT_NEXT;
    // Sentinel takes priority: a full buffer may still be closed normally.
    if (is_sentinel) begin
      capture_outcome = OUT_DONE;
    end else if (is_full || out_of_range) begin
      capture_outcome = OUT_ERR;
    end
  end

  assign store = capture && (capture_outcome == OUT_NEXT);

  // -------------------------------------------------------------------------
  // Handshake / transfer FSM
  // -------------------------------------------------------------------------
  path_handshake_rx u_handshake_rx (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .gave_coord      (gave_coord),
    .capture_outcome (capture_outcome),
    .arm             (arm),
    .capture         (capture),
    .received_coord  (received_coord),
    .finished        (finished),
    .error           (error)
  );

  // -------------------------------------------------------------------------
  // Length counter. A new start clears only the count; old buffer entries
  // are left in place and are simply beyond length.
  // -------------------------------------------------------------------------
  always_comb begin
    len_next = len_reg;
    if (arm) begin
      len_next = '0;
    end else if (store) begin
      len_next = len_reg + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_reg <= '0;
    end else begin
      len_reg <= len_next;
    end
  end

  assign length = 32'(len_reg);

  // -------------------------------------------------------------------------
  // Path buffer. Entries must clear on reset, so this is a register file
  // with one write-enable decode per entry rather than a RAM.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_path
      coord_t entry_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          entry_reg <= '0;
        end else if (store && (len_reg == LEN_W'(gi))) begin
          entry_reg <= coord;
        end
      end

      assign path[gi] = entry_reg;
    end
  endgenerate

endmodule
